// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, the default FIFO depth and the wrapping
//               pointer-increment helper for the UART transmit FIFO.
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
package uart_pkg;

    typedef logic [7:0] uart_char_t;

    localparam int UART_FIFO_DEPTH = 16;

    // Advance a storage index by one, wrapping from depth-1 back to zero so
    // that depths which are not a power of two work correctly.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ring_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ring_fifo_if
// Description : Character-in / character-out valid-ready handshake bundle of
//               the UART transmit FIFO. The FIFO takes the slave side.
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
interface uart_tx_ring_fifo_if import uart_pkg::*; #(
    parameter int DATA_WIDTH = $bits(uart_char_t)
) ();

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid
    );

    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid
    );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x DATA_WIDTH register file, one synchronous write port
//               and one asynchronous read port.
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage contents carry no reset; the control logic never reads an unwritten entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_tx_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ring_fifo
// Description : Circular-buffer FIFO feeding the UART transmitter. Read/write
//               pointers plus occupancy count, a registered valid/ready output
//               stage with empty-FIFO bypass, flush, almost-full and sticky
//               overflow status.
//               Optional macro UART_TX_FIFO_DROP_CNT_EN adds a saturating
//               16-bit count of rejected writes on port drop_count.
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
module uart_tx_ring_fifo import uart_pkg::*; #(
    parameter int DATA_WIDTH   = $bits(uart_char_t),
    parameter int DEPTH        = UART_FIFO_DEPTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ena,
    input  logic                       flush,
    uart_tx_ring_fifo_if.slave         bus,
    output logic [$clog2(DEPTH+2)-1:0] level,
    output logic                       almost_full,
    output logic                       overflow
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LVL_W = $clog2(DEPTH + 2);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;
    logic [DATA_WIDTH-1:0] rd_data;

    logic in_ready;
    logic accept;
    logic pop;
    logic stage_free;
    logic load;
    logic bypass;
    logic mem_wr;
    logic reject;

    // Full blocks writes even when a pop happens in the same cycle, so in_ready
    // never depends on tx_ready.
    assign in_ready   = ena & ~flush & (count != CNT_W'(DEPTH));
    assign accept     = bus.in_valid & in_ready;
    assign pop        = stage_valid & bus.tx_ready & ena;
    assign stage_free = ~stage_valid | pop;
    assign load       = stage_free & (count != '0);
    assign bypass     = stage_free & (count == '0) & accept;
    assign mem_wr     = accept & ~bypass;
    assign reject     = ena & ~flush & bus.in_valid & ~in_ready;

    assign bus.in_ready = in_ready;
    assign bus.tx_valid = stage_valid;
    assign bus.tx_data  = stage_data;

    assign level       = LVL_W'(count) + LVL_W'(stage_valid);
    assign almost_full = (32'(level) >= 32'(AFULL_THRESH));

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr),
        .wr_addr (wr_ptr),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Pointer, occupancy, output-stage and overflow-flag update; ena low freezes all.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            overflow    <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                stage_valid <= 1'b0;
                overflow    <= 1'b0;
            end else begin
                if (mem_wr) begin
                    wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
                end
                if (load) begin
                    rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
                end
                if (mem_wr && !load) begin
                    count <= count + CNT_W'(1);
                end else if (!mem_wr && load) begin
                    count <= count - CNT_W'(1);
                end
                if (load) begin
                    stage_valid <= 1'b1;
                    stage_data  <= rd_data;
                end else if (bypass) begin
                    stage_valid <= 1'b1;
                    stage_data  <= bus.in_data;
                end else if (pop) begin
                    stage_valid <= 1'b0;
                end
                if (reject) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    // Saturating tally of rejected writes, cleared together with the overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (ena) begin
            if (flush) begin
                drop_count <= '0;
            end else if (reject && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ring_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ring_fifo
// Description : Scoreboard bench for uart_tx_ring_fifo (DEPTH=16,
//               AFULL_THRESH=12). The driver queues every accepted character;
//               a monitor pops and compares on every transmitter handshake.
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
module tb_uart_tx_ring_fifo;

    logic       clk;
    logic       reset_n;
    logic       ena;
    logic       flush;
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int         errors;
    int         checks;
    int         n_popped;
    logic [7:0] q[$];
    logic [7:0] nxt;

    uart_tx_ring_fifo_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ring_fifo #(
        .DATA_WIDTH   (8),
        .DEPTH        (16),
        .AFULL_THRESH (12)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ena         (ena),
        .flush       (flush),
        .bus         (bus),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        #1;
        if (bus.in_ready) q.push_back(d);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        bus.tx_ready = 1'b1;
        while (bus.tx_valid && budget < 40) begin
            cyc();
            budget++;
        end
        chk("drain_done", 32'(bus.tx_valid), 32'd0);
        chk("drain_sb_empty", 32'(q.size()), 32'd0);
        bus.tx_ready = 1'b0;
    endtask

    task automatic monitor();
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset_n && ena && !flush && bus.tx_valid && bus.tx_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no character", bus.tx_data);
                end else begin
                    exp = q.pop_front();
                    chk("tx_order", 32'(bus.tx_data), 32'(exp));
                    n_popped++;
                end
            end
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        n_popped     = 0;
        reset_n      = 1'b0;
        ena          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        cyc();
        cyc();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;

        // Single character, one-cycle latency, held while tx_ready low
        send(8'h41);
        chk("t1_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'h41);
        chk("t1_level", 32'(level), 32'd1);
        repeat (3) begin
            cyc();
            chk("t1_hold_data", 32'(bus.tx_data), 32'h41);
            chk("t1_hold_level", 32'(level), 32'd1);
        end
        drain();

        // Fill to level 17, almost_full from 12, then one rejected write
        for (int i = 0; i < 17; i++) begin
            send(8'(i));
            chk("t2_level", 32'(level), 32'(i + 1));
            chk("t2_almost_full", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
        end
        chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("t2_overflow_pre", 32'(overflow), 32'd0);
        send(8'h11);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_level_after_drop", 32'(level), 32'd17);
        chk("t2_head", 32'(bus.tx_data), 32'h00);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("t2_drop_count", 32'(drop_count), 32'd1);
`endif

        // Stream from full with tx_ready high: no gaps, pointer wrap, in order
        bus.tx_ready = 1'b1;
        bus.in_valid = 1'b1;
        nxt = 8'h11;
        for (int c = 0; c < 40; c++) begin
            bus.in_data = nxt;
            #1;
            if (bus.in_ready) begin
                q.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            cyc();
            chk("t3_no_gap", 32'(bus.tx_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        chk("t3_level", 32'(level), 32'd16);
        drain();
        chk("t3_total_popped", 32'(n_popped), 32'd57);

        // Flush at level 9 with a concurrent write
        for (int i = 0; i < 9; i++) send(8'h60 + 8'(i));
        chk("t5_level_pre", 32'(level), 32'd9);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        q.delete();
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_almost_full", 32'(almost_full), 32'd0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("t5_drop_count", 32'(drop_count), 32'd0);
`endif
        send(8'h7A);
        chk("t5_next_valid", 32'(bus.tx_valid), 32'd1);
        chk("t5_next_data", 32'(bus.tx_data), 32'h7A);
        chk("t5_next_level", 32'(level), 32'd1);
        drain();

        // ena low freezes everything
        send(8'h50);
        send(8'h51);
        send(8'h52);
        chk("t4_level_pre", 32'(level), 32'd3);
        ena          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        bus.tx_ready = 1'b1;
        repeat (5) begin
            #1;
            chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
            cyc();
            chk("t4_level", 32'(level), 32'd3);
            chk("t4_tx_data", 32'(bus.tx_data), 32'h50);
            chk("t4_tx_valid", 32'(bus.tx_valid), 32'd1);
        end
        ena          = 1'b1;
        bus.in_valid = 1'b0;
        chk("t4_overflow", 32'(overflow), 32'd0);
        drain();

        // Reset mid-stream overrides ena=0 and flush=1
        for (int i = 0; i < 17; i++) send(8'h80 + 8'(i));
        send(8'h91);
        chk("t6_overflow_pre", 32'(overflow), 32'd1);
        chk("t6_almost_full_pre", 32'(almost_full), 32'd1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("t6_drop_count_pre", 32'(drop_count), 32'd1);
`endif
        reset_n      = 1'b0;
        ena          = 1'b0;
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        bus.tx_ready = 1'b1;
        q.delete();
        cyc();
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("t6_tx_data", 32'(bus.tx_data), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_almost_full", 32'(almost_full), 32'd0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("t6_drop_count", 32'(drop_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
